// File: rtl/blk_serialize.sv
// blk_serialize: buffers 4-row image beats, re-emits each as four 4x4 RGBA blocks (coords under BLK_SERIALIZE_COORD_EN).
// Latency: a beat written at edge E0 shows block 0 after E2; one block per cycle after that.
// Backpressure: i_blk_rdy stalls the block output; the beat input has none, so beats arriving while full are dropped and set o_ovf.
module blk_serialize #(
  parameter int BAND_WIDTH = 512,
  parameter int BLK_WIDTH  = 4,
  parameter int IM_CHN_CNT = 4,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_done,
  input  logic [BLK_WIDTH*BAND_WIDTH-1:0]           i_im_data,
  input  logic                                      i_im_vld,
  input  logic                                      i_im_in_last,
  output logic [BLK_WIDTH*BLK_WIDTH*IM_CHN_CNT*8-1:0] o_blk_data,
  output logic                                      o_blk_vld,
  input  logic                                      i_blk_rdy,
  output logic                                      o_blk_last,
  output logic [7:0]                                o_blk_x,
  output logic [7:0]                                o_blk_y,
  output logic                                      o_ovf
);

  localparam int BEAT_W    = BLK_WIDTH * BAND_WIDTH;
  localparam int ROW_W     = BLK_WIDTH * IM_CHN_CNT * 8;
  localparam int BLK_W     = BLK_WIDTH * ROW_W;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int BEAT_COLS = 50;
  localparam int STRIPES   = 200;

  // Each entry carries the last-of-frame tag in its top bit.
  logic [BEAT_W:0] mem [FIFO_DEPTH];

  logic [AW:0]     wr_ptr;
  logic [AW:0]     wr_ptr_d;
  logic [AW:0]     rd_ptr;
  logic [AW:0]     cnt;
  logic [1:0]      phase;
  logic            full;
  logic            push;
  logic            accept;
  logic            pop;

  logic [AW:0]     nxt_ptr;
  logic [1:0]      nxt_phase;
  logic            nxt_avail;
  logic [BEAT_W:0] nxt_beat;
  logic [BLK_W-1:0] nxt_blk;

  assign cnt    = wr_ptr - rd_ptr;
  assign full   = (cnt == (AW+1)'(FIFO_DEPTH));
  assign push   = i_im_vld && !full && !i_done;
  assign accept = o_blk_vld && i_blk_rdy;
  assign pop    = accept && (phase == 2'd3);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {i_im_in_last, i_im_data};
    end
  end

  // A beat only becomes visible to the output stage through the delayed write
  // pointer, which gives the two-edge fill latency without a bubble later on.
  always_comb begin
    nxt_ptr   = pop ? rd_ptr + (AW+1)'(1) : rd_ptr;
    nxt_phase = accept ? phase + 2'd1 : phase;
    nxt_avail = (nxt_ptr != wr_ptr_d);
    nxt_beat  = mem[nxt_ptr[AW-1:0]];
    nxt_blk   = '0;
    for (int r = 0; r < BLK_WIDTH; r++) begin
      nxt_blk[r*ROW_W +: ROW_W] = nxt_beat[r*BAND_WIDTH + int'(nxt_phase)*ROW_W +: ROW_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_done) begin
      wr_ptr     <= '0;
      wr_ptr_d   <= '0;
      rd_ptr     <= '0;
      phase      <= '0;
      o_blk_vld  <= 1'b0;
      o_blk_last <= 1'b0;
      o_blk_data <= '0;
      o_ovf      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      wr_ptr_d <= wr_ptr;
      if (i_im_vld && full) begin
        o_ovf <= 1'b1;
      end
      phase  <= nxt_phase;
      rd_ptr <= nxt_ptr;
      if (!o_blk_vld || i_blk_rdy) begin
        o_blk_vld  <= nxt_avail;
        o_blk_last <= nxt_avail && nxt_beat[BEAT_W] && (nxt_phase == 2'd3);
        if (nxt_avail) begin
          o_blk_data <= nxt_blk;
        end
      end
    end
  end

`ifdef BLK_SERIALIZE_COORD_EN
  logic [5:0] beat_col;
  logic [7:0] stripe;

  always_ff @(posedge clk) begin
    if (rst || i_done) begin
      beat_col <= '0;
      stripe   <= '0;
    end else if (pop) begin
      if (beat_col == 6'(BEAT_COLS - 1)) begin
        beat_col <= '0;
        stripe   <= (stripe == 8'(STRIPES - 1)) ? 8'd0 : stripe + 8'd1;
      end else begin
        beat_col <= beat_col + 6'd1;
      end
    end
  end

  // beat_col*4 + phase
  assign o_blk_x = {beat_col, phase};
  assign o_blk_y = stripe;
`else
  assign o_blk_x = '0;
  assign o_blk_y = '0;
`endif

endmodule

// File: tb/tb_blk_serialize.sv
// Bench for blk_serialize: directed stimulus against a queue-based beat/block model.
`timescale 1ns/1ps
module tb_blk_serialize;
  localparam int BW    = 512;
  localparam int DEPTH = 64;
  localparam int IW    = 4 * BW;
  localparam int OW    = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_done;
  logic [IW-1:0] i_im_data;
  logic          i_im_vld;
  logic          i_im_in_last;
  logic [OW-1:0] o_blk_data;
  logic          o_blk_vld;
  logic          i_blk_rdy;
  logic          o_blk_last;
  logic [7:0]    o_blk_x;
  logic [7:0]    o_blk_y;
  logic          o_ovf;

  blk_serialize #(.BAND_WIDTH(BW), .BLK_WIDTH(4), .IM_CHN_CNT(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_done(i_done),
    .i_im_data(i_im_data), .i_im_vld(i_im_vld), .i_im_in_last(i_im_in_last),
    .o_blk_data(o_blk_data), .o_blk_vld(o_blk_vld), .i_blk_rdy(i_blk_rdy),
    .o_blk_last(o_blk_last), .o_blk_x(o_blk_x), .o_blk_y(o_blk_y), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int cx(input int v);
`ifdef BLK_SERIALIZE_COORD_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Block j row r = pixels 4j..4j+3 of row r, pixel p at bits p*32 of its row.
  function automatic logic [OW-1:0] blk_of(input logic [IW-1:0] beat, input int j);
    logic [OW-1:0] b;
    b = '0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        b[r*128 + k*32 +: 32] = beat[r*BW + (4*j + k)*32 +: 32];
    return b;
  endfunction

  function automatic logic [IW-1:0] rnd_beat();
    logic [IW-1:0] d;
    for (int i = 0; i < IW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // ---------------- model ----------------
  logic [IW-1:0] beat_q[$];
  bit            last_q[$];
  int  sub = 0, blk_acc = 0, n_blocks = 0, n_last = 0, max_occ = 0;
  int  last_x = -1, last_y = -1;
  int  m_b;
  bit  exp_ovf = 0, prev_stall = 0, m_full;
  logic [OW-1:0] prev_dat;
  logic [7:0]    prev_x, prev_y;
  logic          prev_last;

  always @(negedge clk) begin
    if (rst || i_done) begin
      beat_q.delete();
      last_q.delete();
      sub = 0; blk_acc = 0; exp_ovf = 0; prev_stall = 0;
    end else begin
      m_full = (beat_q.size() == DEPTH);
      chk("ovf", o_ovf, exp_ovf);
      if (prev_stall) begin
        chk("hold_vld", o_blk_vld, 1'b1);
        chk("hold_dat", o_blk_data, prev_dat);
        chk("hold_x", o_blk_x, prev_x);
        chk("hold_y", o_blk_y, prev_y);
        chk("hold_last", o_blk_last, prev_last);
      end
      if (o_blk_vld && beat_q.size() == 0) begin
        chk("spurious_vld", o_blk_vld, 1'b0);
      end else if (o_blk_vld && i_blk_rdy) begin
        m_b = blk_acc / 4;
        chk("blk_dat", o_blk_data, blk_of(beat_q[0], sub));
        chk("blk_last", o_blk_last, last_q[0] && sub == 3);
        chk("blk_x", o_blk_x, cx((m_b % 50) * 4 + blk_acc % 4));
        chk("blk_y", o_blk_y, cx((m_b / 50) % 200));
        n_blocks++;
        if (o_blk_last) begin
          n_last++; last_x = o_blk_x; last_y = o_blk_y;
        end
        blk_acc++;
        sub++;
        if (sub == 4) begin
          sub = 0;
          void'(beat_q.pop_front());
          void'(last_q.pop_front());
        end
      end
      if (i_im_vld) begin
        if (m_full) exp_ovf = 1;
        else begin
          beat_q.push_back(i_im_data);
          last_q.push_back(i_im_in_last);
        end
      end
      if (beat_q.size() > max_occ) max_occ = beat_q.size();
      prev_stall = o_blk_vld && !i_blk_rdy;
      prev_dat = o_blk_data; prev_x = o_blk_x; prev_y = o_blk_y; prev_last = o_blk_last;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [IW-1:0] d, input logic last);
    i_im_data = d; i_im_in_last = last; i_im_vld = 1'b1;
    step();
    i_im_vld = 1'b0; i_im_in_last = 1'b0;
  endtask

  task automatic done_pulse();
    i_done = 1'b1;
    step();
    i_done = 1'b0;
  endtask

  task automatic drain(input int max);
    int i;
    i = 0;
    while ((beat_q.size() != 0 || o_blk_vld) && i < max) begin
      step();
      i++;
    end
    chk("drain_done", beat_q.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_vld"}, o_blk_vld, 1'b0);
    chk({tag, "_last"}, o_blk_last, 1'b0);
    chk({tag, "_ovf"}, o_ovf, 1'b0);
    chk({tag, "_x"}, o_blk_x, 8'd0);
    chk({tag, "_y"}, o_blk_y, 8'd0);
    chk({tag, "_dat"}, o_blk_data, '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [IW-1:0] d;
    int base, base_last;
    rst = 1'b1; i_done = 1'b0; i_im_vld = 1'b0; i_im_in_last = 1'b0;
    i_im_data = '0; i_blk_rdy = 1'b0;

    // reset state
    step(); step();
    @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    step();

    // single beat, pixel value = row*256 + pixel index
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < 16; p++)
        d[r*BW + p*32 +: 32] = 32'(r*256 + p);
    i_blk_rdy = 1'b1;
    push(d, 1'b0);
    @(negedge clk); chk("lat_e0", o_blk_vld, 1'b0);
    step(); @(negedge clk); chk("lat_e1", o_blk_vld, 1'b0);
    step(); @(negedge clk);
    chk("lat_e2", o_blk_vld, 1'b1);
    chk("x_b0", o_blk_x, cx(0));
    chk("px_b0_r1_k2", o_blk_data[1*128 + 2*32 +: 32], 32'h0000_0102);
    step(); @(negedge clk);
    chk("x_b1", o_blk_x, cx(1));
    chk("px_b1_r2_k3", o_blk_data[2*128 + 3*32 +: 32], 32'h0000_0207);
    step(); @(negedge clk);
    chk("x_b2", o_blk_x, cx(2));
    step(); @(negedge clk);
    chk("x_b3", o_blk_x, cx(3));
    chk("vld_b3", o_blk_vld, 1'b1);
    chk("px_b3_r3_k0", o_blk_data[3*128 +: 32], 32'h0000_030C);
    step(); @(negedge clk);
    chk("after_4", o_blk_vld, 1'b0);

    // random ready over one stripe burst
    done_pulse();
    base = n_blocks;
    for (int b = 0; b < 50; b++) begin
      i_blk_rdy = 1'($urandom_range(0, 1));
      push(rnd_beat(), b == 49);
    end
    for (int i = 0; i < 2000 && (beat_q.size() != 0 || o_blk_vld); i++) begin
      i_blk_rdy = 1'($urandom_range(0, 1));
      step();
    end
    chk("rand_drain", beat_q.size(), 0);
    chk("rand_blocks", n_blocks - base, 200);
    i_blk_rdy = 1'b1;

    // overflow: 65 beats with the consumer stalled
    done_pulse();
    i_blk_rdy = 1'b0;
    for (int b = 0; b < 64; b++) push(rnd_beat(), 1'b0);
    @(negedge clk); chk("ovf_pre", o_ovf, 1'b0);
    push(rnd_beat(), 1'b0);
    @(negedge clk); chk("ovf_post", o_ovf, 1'b1);
    base = n_blocks;
    i_blk_rdy = 1'b1;
    drain(2000);
    chk("blocks_256", n_blocks - base, 256);

    // i_done alongside a beat, mid-stripe, with o_ovf still set
    for (int b = 0; b < 10; b++) push(rnd_beat(), 1'b0);
    i_im_data = rnd_beat(); i_im_vld = 1'b1; i_done = 1'b1;
    step();
    i_im_vld = 1'b0; i_done = 1'b0;
    @(negedge clk);
    chk("done_vld", o_blk_vld, 1'b0);
    chk("done_ovf", o_ovf, 1'b0);
    chk("done_x", o_blk_x, 8'd0);
    chk("done_y", o_blk_y, 8'd0);
    repeat (4) step();
    @(negedge clk); chk("done_not_stored", o_blk_vld, 1'b0);

    // rst while block 2 of a beat is presented
    push(rnd_beat(), 1'b0);
    repeat (4) step();
    @(negedge clk);
    chk("pre_rst_vld", o_blk_vld, 1'b1);
    chk("pre_rst_x", o_blk_x, cx(2));
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst_mid");
    repeat (3) step();
    @(negedge clk); chk("rst_discard", o_blk_vld, 1'b0);

    // full frame: 200 stripes of 50 beats, 200 cycles per stripe
    done_pulse();
    base = n_blocks; base_last = n_last; max_occ = 0;
    i_blk_rdy = 1'b1;
    for (int s = 0; s < 200; s++) begin
      for (int b = 0; b < 50; b++) push(rnd_beat(), s == 199 && b == 49);
      repeat (150) step();
    end
    drain(2000);
    chk("frame_blocks", n_blocks - base, 40000);
    chk("frame_last_cnt", n_last - base_last, 1);
    chk("frame_last_x", last_x, cx(199));
    chk("frame_last_y", last_y, cx(199));
    chk("frame_ovf", o_ovf, 1'b0);
    chk("frame_occ_le50", (max_occ <= 50) ? 1 : 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/blk_serialize.md
# blk_serialize

Downstream neighbour of the 4-row input buffer in the add-watermark kernel. Takes the 4-row-parallel image beats (4 × 512 bit) that the buffer emits during every fourth row. Stores them in an internal beat FIFO. Re-emits each beat as four 4×4-pixel RGBA blocks, one per cycle, under a valid/ready handshake toward the block processing engine. The input side has no backpressure, so the FIFO absorbs the 50-beat burst per stripe and flags overflow.

## Interface
Parameters:
- BAND_WIDTH, 512, bits per row slice of an input beat (16 RGBA pixels)
- BLK_WIDTH, 4, block edge in pixels; also the number of rows per input beat
- IM_CHN_CNT, 4, channels per pixel, 8 bit each
- FIFO_DEPTH, 64, input beats stored, power of two, ≥ 50

Ports:
- clk  in  1  kernel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- i_done  in  1  end-of-kernel pulse; synchronous clear of all state
- i_im_data  in  BLK_WIDTH*BAND_WIDTH  row r at [r*BAND_WIDTH +: BAND_WIDTH], r = 0..3
- i_im_vld  in  1  beat valid; no backpressure
- i_im_in_last  in  1  qualifies the last beat of the frame
- o_blk_data  out  BLK_WIDTH*BLK_WIDTH*IM_CHN_CNT*8 (512)  4×4 block
- o_blk_vld  out  1  block valid
- i_blk_rdy  in  1  consumer ready
- o_blk_last  out  1  last block of the frame
- o_blk_x  out  8  block column, 0..199
- o_blk_y  out  8  block stripe, 0..199
- o_ovf  out  1  sticky overflow flag

## Operation
- Beat layout:
  - Pixel p (0..15) of row r sits at row_slice[p*32 +: 32].
  - Block j (0..3) covers pixels 4j..4j+3.
  - o_blk_data[r*128 +: 128] = row_slice_r[j*128 +: 128].
- FIFO:
  - Width is 2048 data bits plus 1 last-tag bit; depth is FIFO_DEPTH; the count includes the beat currently being serialized.
  - Push: i_im_vld && !full && !i_done.
  - Pop: the phase-3 block of the head beat is accepted.
- Serializer:
  - A 2-bit phase counter selects the block j.
  - A block is accepted when o_blk_vld && i_blk_rdy; each acceptance advances the phase, and the phase wraps 3→0 with a pop.
- Coordinates:
  - o_blk_x = beat_col*4 + phase, where beat_col runs 0..49 and wraps at 49.
  - o_blk_y increments when o_blk_x wraps 199→0, and wraps 199→0.
- Last flag: o_blk_last = o_blk_vld && head last-tag && phase == 3.
- Overflow:
  - i_im_vld while full: the beat is dropped and o_ovf sets.
  - A push while full is dropped even if a pop occurs in the same cycle.
  - o_ovf holds until rst or i_done.
- i_done: clears the FIFO pointers and count, phase, o_blk_x, o_blk_y, o_blk_vld and o_ovf. It wins over a same-cycle i_im_vld or acceptance.
- Reset values: o_blk_vld = 0, o_blk_last = 0, o_ovf = 0, o_blk_x = 0, o_blk_y = 0, o_blk_data = 0.

## Timing
- Latency: a beat written into an empty FIFO at edge E0 presents block 0 with o_blk_vld = 1 after edge E2.
- Throughput: one block per cycle while i_blk_rdy = 1; back-to-back beats produce no bubbles.
- Data stability: while o_blk_vld && !i_blk_rdy, o_blk_data, o_blk_x, o_blk_y and o_blk_last hold stable.
- Valid rule: o_blk_vld never drops without an acceptance, except on rst or i_done.
- Steady-state budget: 50 beats per stripe give 200 blocks per 200-cycle stripe. With i_blk_rdy held high, FIFO occupancy never exceeds 50.
- rst mid-frame: all state returns to reset values on the next edge; a partially emitted beat is discarded.

## Configuration
- BLK_SERIALIZE_COORD_EN:
  - Defined: the o_blk_x/o_blk_y counters are compiled in as described above.
  - Undefined: the counters are omitted and o_blk_x/o_blk_y are tied to 0. All other behaviour is unchanged.

## Test plan
- Single beat, rows filled with pixel index p, i_blk_rdy = 1:
  - Four blocks appear on consecutive cycles starting 2 cycles after the write.
  - Block j row r equals pixels 4j..4j+3 of row r.
  - o_blk_x = 0, 1, 2, 3.
- Full frame, 200 stripes × 50 beats, i_blk_rdy = 1:
  - 40000 blocks.
  - o_blk_last exactly once, on x = 199, y = 199.
  - o_ovf = 0.
- Random i_blk_rdy (50 %) for one stripe burst:
  - No block is lost or duplicated.
  - Outputs stay stable during stalls.
- i_blk_rdy = 0 with 65 beats pushed:
  - The first 64 beats are stored and beat 65 is dropped.
  - o_ovf = 1 the cycle after the dropped beat.
  - After ready is released, exactly 256 blocks are emitted.
- i_done asserted mid-stripe alongside i_im_vld:
  - The next cycle shows o_blk_vld = 0, o_ovf = 0, x = y = 0.
  - That beat is not stored.
- rst pulse during serialization phase 2: all outputs return to their reset values the next cycle.
